// File: rtl/bus_arbiter.sv
// Registered bus arbiter: one-hot grant, registered data mux, fixed or round-robin priority.
// Optional forced-release hold timer is compiled in with `define BUS_TIMEOUT_EN.
module bus_arbiter #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 5,
  parameter int MODE     = 0,
  parameter int TIMEOUT  = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       req,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  output logic [CHANNELS-1:0]       grant,
  output logic [WIDTH-1:0]          out,
  output logic                      out_valid,
  output logic [3:0]                owner,
  output logic                      timeout
);

  if ((CHANNELS < 2) || (CHANNELS > 16) || (TIMEOUT < 1) || (MODE < 0) || (MODE > 1)) begin : g_param_check
    $error("bus_arbiter: illegal parameter combination");
  end

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [CHANNELS-1:0]   grant_q, grant_d;
  logic [3:0]            owner_q, owner_d;
  logic [3:0]            ptr_q, ptr_d;
  logic [WIDTH-1:0]      out_q, out_d;
  logic                  out_valid_q, out_valid_d;
  logic                  timeout_q, timeout_d;

  logic                  owner_req_s;
  logic                  force_s;
  logic                  arb_s;
  logic [CHANNELS-1:0]   elig_s;
  logic                  win_found_s;
  logic [3:0]            win_idx_s;

  // grant_q is one-hot of the owner while OWNED, so it doubles as the owner mask
  assign owner_req_s = |(req & grant_q);

`ifdef BUS_TIMEOUT_EN
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  logic [CW-1:0] hold_q, hold_d;

  assign force_s = (state_q == OWNED) && owner_req_s && (hold_q == CW'(TIMEOUT - 1));
`else
  assign force_s = 1'b0;
`endif

  assign arb_s  = (state_q == IDLE) || !owner_req_s || force_s;
  assign elig_s = force_s ? (req & ~grant_q) : req;

  // Winner search: lowest index, or nearest index after the pointer in round-robin order
  always_comb begin
    int best_v;
    int dist_v;
    win_found_s = 1'b0;
    win_idx_s   = 4'd0;
    best_v      = CHANNELS;
    dist_v      = 0;
    if (MODE == 1) begin
      for (int i = 0; i < CHANNELS; i++) begin
        dist_v = (i + 2 * CHANNELS - int'(ptr_q) - 1) % CHANNELS;
        if (elig_s[i] && (dist_v < best_v)) begin
          best_v      = dist_v;
          win_found_s = 1'b1;
          win_idx_s   = 4'(i);
        end else begin
          best_v = best_v;
        end
      end
    end else begin
      for (int i = CHANNELS - 1; i >= 0; i--) begin
        if (elig_s[i]) begin
          win_found_s = 1'b1;
          win_idx_s   = 4'(i);
        end else begin
          win_found_s = win_found_s;
        end
      end
    end
  end

  // Next-state, grant hand-over and registered data mux
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    timeout_d   = force_s;
    out_valid_d = |grant_q;
    out_d       = {WIDTH{1'b0}};
`ifdef BUS_TIMEOUT_EN
    hold_d      = hold_q;
`endif
    for (int i = 0; i < CHANNELS; i++) begin
      out_d = out_d | ({WIDTH{grant_q[i]}} & data_in[i*WIDTH +: WIDTH]);
    end
    if (arb_s) begin
      if (win_found_s) begin
        state_d = OWNED;
        grant_d = {{(CHANNELS-1){1'b0}}, 1'b1} << win_idx_s;
        owner_d = win_idx_s;
        ptr_d   = (MODE == 1) ? win_idx_s : ptr_q;
      end else begin
        state_d = IDLE;
        grant_d = {CHANNELS{1'b0}};
        owner_d = 4'd0;
      end
`ifdef BUS_TIMEOUT_EN
      hold_d = {CW{1'b0}};
`endif
    end else begin
`ifdef BUS_TIMEOUT_EN
      hold_d = hold_q + {{(CW-1){1'b0}}, 1'b1};
`endif
      state_d = state_q;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= {CHANNELS{1'b0}};
      owner_q     <= 4'd0;
      ptr_q       <= 4'(CHANNELS - 1);
      out_q       <= {WIDTH{1'b0}};
      out_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      owner_q     <= owner_d;
      ptr_q       <= ptr_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      timeout_q   <= timeout_d;
    end
  end

`ifdef BUS_TIMEOUT_EN
  // Hold timer for the current owner
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= {CW{1'b0}};
    end else begin
      hold_q <= hold_d;
    end
  end
`endif

  assign grant     = grant_q;
  assign owner     = owner_q;
  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign timeout   = timeout_q;

endmodule
